// File: rtl/traffic_pkg.sv
// Shared types and constants for the pedestrian-crossing traffic light controller.
package traffic_pkg;

  localparam int unsigned DWELL_W   = 4;
  localparam int unsigned TICKS_MAX = 15;

  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_WALK   = 2'd2,
    ST_CLEAR  = 2'd3
  } state_e;

  localparam logic [2:0] CAR_GREEN  = 3'b001;
  localparam logic [2:0] CAR_YELLOW = 3'b010;
  localparam logic [2:0] CAR_RED    = 3'b100;

  typedef struct packed {
    logic [2:0] car;
    logic       walk;
  } lamps_t;

  // Lamp pattern shown while in a given state; walk only ever lights with car red.
  function automatic lamps_t lamps_of(state_e st);
    lamps_t l;
    l.car  = CAR_RED;
    l.walk = 1'b0;
    case (st)
      ST_GREEN:  l.car  = CAR_GREEN;
      ST_YELLOW: l.car  = CAR_YELLOW;
      ST_WALK:   l.walk = 1'b1;
      default:   ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_light_fsm_dwell_counter.sv
// Dwell counter: clear wins over count; saturate freezes the value.
module dwell_counter
  import traffic_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic               sat,
  output logic [DWELL_W-1:0] count
);

  logic [DWELL_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en && !sat) begin
      r_count <= r_count + DWELL_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/traffic_light_fsm.sv
// Traffic light with pedestrian crossing: GREEN -> YELLOW -> WALK -> CLEAR,
// advancing on divider ticks once each phase has dwelt its configured length.
module traffic_light_fsm
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_TICKS  = 8,
  parameter int unsigned YELLOW_TICKS = 3,
  parameter int unsigned WALK_TICKS   = 6,
  parameter int unsigned CLEAR_TICKS  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               ped_req,
  output logic               ped_ack,
  output logic [2:0]         car_light,
  output logic               walk,
  output logic [DWELL_W-1:0] dwell
);

  if (GREEN_TICKS == 0 || GREEN_TICKS > TICKS_MAX ||
      YELLOW_TICKS == 0 || YELLOW_TICKS > TICKS_MAX ||
      WALK_TICKS == 0 || WALK_TICKS > TICKS_MAX ||
      CLEAR_TICKS == 0 || CLEAR_TICKS > TICKS_MAX) begin : g_param_err
    $error("traffic_light_fsm: every *_TICKS parameter must lie in 1..15");
  end

  localparam logic [DWELL_W-1:0] G_LAST = DWELL_W'(GREEN_TICKS - 1);
  localparam logic [DWELL_W-1:0] Y_LAST = DWELL_W'(YELLOW_TICKS - 1);
  localparam logic [DWELL_W-1:0] W_LAST = DWELL_W'(WALK_TICKS - 1);
  localparam logic [DWELL_W-1:0] C_LAST = DWELL_W'(CLEAR_TICKS - 1);

  state_e             r_state;
  state_e             w_next;
  lamps_t             r_lamps;
  logic               r_req;
  logic               r_ack;
  logic               r_armed;
  logic               w_tick;
  logic               w_at_end;
  logic               w_sat;
  logic               w_clr;
  logic               w_serve;
  logic [DWELL_W-1:0] w_last;
  logic [DWELL_W-1:0] w_count;

  // The first edge after reset release is ignored so a coincident tick is not counted.
  assign w_tick = tick & r_armed;

  dwell_counter u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_tick),
    .clr   (w_clr),
    .sat   (w_sat),
    .count (w_count)
  );

  // Next-state: GREEN waits for a latched request, other phases advance unconditionally.
  always_comb begin
    w_next = r_state;
    w_last = G_LAST;
    case (r_state)
      ST_GREEN:  w_last = G_LAST;
      ST_YELLOW: w_last = Y_LAST;
      ST_WALK:   w_last = W_LAST;
      ST_CLEAR:  w_last = C_LAST;
      default:   w_last = G_LAST;
    endcase
    w_at_end = (w_count == w_last);
    case (r_state)
      ST_GREEN:  if (w_tick && w_at_end && r_req) w_next = ST_YELLOW;
      ST_YELLOW: if (w_tick && w_at_end)          w_next = ST_WALK;
      ST_WALK:   if (w_tick && w_at_end)          w_next = ST_CLEAR;
      ST_CLEAR:  if (w_tick && w_at_end)          w_next = ST_GREEN;
      default:   w_next = ST_GREEN;
    endcase
  end

  assign w_sat   = (r_state == ST_GREEN) && w_at_end;
  assign w_clr   = (w_next != r_state);
  assign w_serve = (r_state == ST_YELLOW) && (w_next == ST_WALK);

  // Lamps are registered from next-state so they move on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_GREEN;
      r_lamps <= lamps_of(ST_GREEN);
      r_req   <= 1'b0;
      r_ack   <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      r_state <= w_next;
      r_lamps <= lamps_of(w_next);
      r_ack   <= w_serve;
      r_req   <= ped_req | (r_req & ~w_serve);
    end
  end

  assign ped_ack   = r_ack;
  assign car_light = r_lamps.car;
  assign walk      = r_lamps.walk;
  assign dwell     = w_count;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Bench for traffic_light_fsm: a reference vector table, then idle, normal,
// set-priority, async-reset and tick-gate sequences against a cycle model.
module tb_traffic_light_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       ped_req;
  logic       ped_ack;
  logic [2:0] car_light;
  logic       walk;
  logic [3:0] dwell;

  always #5 clk = ~clk;

  traffic_light_fsm #(
    .GREEN_TICKS  (8),
    .YELLOW_TICKS (3),
    .WALK_TICKS   (6),
    .CLEAR_TICKS  (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .ped_req   (ped_req),
    .ped_ack   (ped_ack),
    .car_light (car_light),
    .walk      (walk),
    .dwell     (dwell)
  );

  typedef struct packed {
    logic [2:0] car;
    logic       walk;
    logic [3:0] dwell;
    logic       ack;
  } exp_t;

  typedef struct {
    logic t;
    logic r;
    exp_t e;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[16];
  int   checks = 0;
  int   failures = 0;

  // Reference model: phase index 0..3 = green, yellow, walk, clear.
  int   dur[4] = '{8, 3, 6, 2};
  int   mst, mcnt;
  bit   mreq, marmed, mack;

  int         tick_no, yellow_at, walk_at, clear_at, green_at, ack_cnt;
  logic [2:0] prev_car;
  logic       prev_walk;

  function automatic exp_t mk(logic [2:0] c, logic w, logic [3:0] d, logic a);
    exp_t e;
    e.car = c; e.walk = w; e.dwell = d; e.ack = a;
    return e;
  endfunction

  function automatic exp_t dut_out();
    return mk(car_light, walk, dwell, ped_ack);
  endfunction

  task automatic model_reset();
    mst = 0; mcnt = 0; mreq = 1'b0; marmed = 1'b0; mack = 1'b0;
  endtask

  function automatic exp_t model_step(bit t, bit r);
    bit   tk;
    bit   serve;
    exp_t e;
    tk     = t && marmed;
    serve  = 1'b0;
    marmed = 1'b1;
    if (tk) begin
      if (mcnt == dur[mst] - 1) begin
        if (mst != 0 || mreq) begin
          serve = (mst == 1);
          mst   = (mst + 1) % 4;
          mcnt  = 0;
        end
      end else begin
        mcnt++;
      end
    end
    mack = serve;
    mreq = r || (mreq && !serve);
    e = mk((mst == 0) ? 3'b001 : (mst == 1) ? 3'b010 : 3'b100, mst == 2, 4'(mcnt), mack);
    return e;
  endfunction

  task automatic check(input string name, input exp_t got, input exp_t want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s @%0t: got car=%b walk=%b dwell=%0d ack=%b, want car=%b walk=%b dwell=%0d ack=%b",
               name, $time, got.car, got.walk, got.dwell, got.ack,
               want.car, want.walk, want.dwell, want.ack);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic clear_events();
    tick_no = 0; yellow_at = -1; walk_at = -1; clear_at = -1; green_at = -1;
    ack_cnt = 0; prev_car = 3'b001; prev_walk = 1'b0;
  endtask

  // Pop the scoreboard, check invariants and log phase changes by tick number.
  task automatic sample(input string name);
    exp_t want;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s: scoreboard empty at %0t", name, $time);
    end else begin
      want = exp_q.pop_front();
      check(name, dut_out(), want);
    end
    checks++;
    if (walk && car_light[1:0] != 2'b00) begin
      failures++;
      $display("FAIL %s_safety: walk=%b with car=%b", name, walk, car_light);
    end
    checks++;
    if (!$onehot(car_light)) begin
      failures++;
      $display("FAIL %s_onehot: car=%b", name, car_light);
    end
    if (ped_ack) ack_cnt++;
    if (car_light != prev_car || walk != prev_walk) begin
      if (car_light == 3'b010)      yellow_at = tick_no;
      else if (walk)                walk_at   = tick_no;
      else if (car_light == 3'b100) clear_at  = tick_no;
      else if (car_light == 3'b001) green_at  = tick_no;
    end
    prev_car  = car_light;
    prev_walk = walk;
  endtask

  task automatic drive(input logic t, input logic r, input string name);
    tick = t; ped_req = r;
    if (t) tick_no++;
    exp_q.push_back(model_step(t, r));
    @(negedge clk);
    sample(name);
  endtask

  task automatic drive_vec(input vec_t v, input string name);
    exp_t unused_e;
    tick = v.t; ped_req = v.r;
    if (v.t) tick_no++;
    unused_e = model_step(v.t, v.r);
    exp_q.push_back(v.e);
    @(negedge clk);
    sample(name);
  endtask

  // Hold reset with tick active (must be ignored), check reset state, release on a negedge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; tick = 1'b1; ped_req = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", dut_out(), mk(3'b001, 1'b0, 4'd0, 1'b0));
    model_reset();
    exp_q.delete();
    tick  = 1'b0;
    rst_n = 1'b1;
    clear_events();
  endtask

  initial begin
    #100000;
    failures++;
    $display("FAIL timeout: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; tick = 1'b0; ped_req = 1'b0;
    model_reset();
    clear_events();

    vecs[0]  = '{1'b1, 1'b0, mk(3'b001, 1'b0, 4'd0, 1'b0)};
    vecs[1]  = '{1'b1, 1'b0, mk(3'b001, 1'b0, 4'd1, 1'b0)};
    vecs[2]  = '{1'b1, 1'b1, mk(3'b001, 1'b0, 4'd2, 1'b0)};
    vecs[3]  = '{1'b0, 1'b0, mk(3'b001, 1'b0, 4'd2, 1'b0)};
    vecs[4]  = '{1'b1, 1'b0, mk(3'b001, 1'b0, 4'd3, 1'b0)};
    vecs[5]  = '{1'b1, 1'b0, mk(3'b001, 1'b0, 4'd4, 1'b0)};
    vecs[6]  = '{1'b1, 1'b0, mk(3'b001, 1'b0, 4'd5, 1'b0)};
    vecs[7]  = '{1'b1, 1'b0, mk(3'b001, 1'b0, 4'd6, 1'b0)};
    vecs[8]  = '{1'b1, 1'b0, mk(3'b001, 1'b0, 4'd7, 1'b0)};
    vecs[9]  = '{1'b0, 1'b0, mk(3'b001, 1'b0, 4'd7, 1'b0)};
    vecs[10] = '{1'b1, 1'b0, mk(3'b010, 1'b0, 4'd0, 1'b0)};
    vecs[11] = '{1'b1, 1'b0, mk(3'b010, 1'b0, 4'd1, 1'b0)};
    vecs[12] = '{1'b1, 1'b0, mk(3'b010, 1'b0, 4'd2, 1'b0)};
    vecs[13] = '{1'b1, 1'b0, mk(3'b100, 1'b1, 4'd0, 1'b1)};
    vecs[14] = '{1'b0, 1'b0, mk(3'b100, 1'b1, 4'd0, 1'b0)};
    vecs[15] = '{1'b1, 1'b0, mk(3'b100, 1'b1, 4'd1, 1'b0)};

    do_reset();
    foreach (vecs[i]) drive_vec(vecs[i], $sformatf("vec%0d", i));

    // Idle: tick every other clock, no requests.
    do_reset();
    for (int k = 0; k < 100; k++) drive(1'(k % 2 == 1), 1'b0, "idle");
    check_int("idle_car", int'(car_light), 1);
    check_int("idle_dwell_sat", int'(dwell), 7);
    check_int("idle_ack_cnt", ack_cnt, 0);

    // Normal cycle: one-clock request at cycle 3.
    do_reset();
    for (int k = 0; k < 23; k++) drive(1'(k >= 1), 1'(k == 3), "normal");
    check_int("normal_yellow_tick", yellow_at, 8);
    check_int("normal_walk_tick", walk_at, 11);
    check_int("normal_clear_tick", clear_at, 17);
    check_int("normal_green_tick", green_at, 19);
    check_int("normal_ack_cnt", ack_cnt, 1);

    // Set priority: request held through the YELLOW->WALK edge only.
    do_reset();
    for (int k = 0; k < 33; k++) drive(1'(k >= 1), 1'(k <= 11), "prio");
    check_int("prio_green_tick", green_at, 19);
    check_int("prio_green_len", yellow_at - green_at, 8);
    check_int("prio_walk2_tick", walk_at, 30);
    check_int("prio_ack_cnt", ack_cnt, 2);

    // Asynchronous reset in the middle of WALK.
    do_reset();
    for (int k = 0; k < 40; k++) begin
      drive(1'(k >= 1), 1'(k == 3), "rst_run");
      if (walk) break;
    end
    check_int("rst_reach_walk", int'(walk), 1);
    drive(1'b1, 1'b0, "rst_run");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_async", dut_out(), mk(3'b001, 1'b0, 4'd0, 1'b0));
    model_reset();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    clear_events();
    drive(1'b1, 1'b1, "rst_release");
    tick_no = 0;
    for (int k = 1; k <= 9; k++) drive(1'b1, 1'b0, "rst_after");
    check_int("rst_yellow_tick", yellow_at, 8);

    // Tick gate: 50 clocks in YELLOW with tick low.
    for (int k = 0; k < 50; k++) drive(1'b0, 1'b0, "gate");
    check_int("gate_car", int'(car_light), 2);
    check_int("gate_dwell", int'(dwell), 1);
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, "gate_resume");
    check_int("gate_walk_tick", walk_at, 11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_light_fsm.md
TRAFFIC_LIGHT_FSM -- requirements
Module: traffic_light_fsm

Interface
REQ-001 SHALL have parameter GREEN_TICKS, default 8, minimum green dwell in ticks (legal range 1..15).
REQ-002 SHALL have parameter YELLOW_TICKS, default 3, yellow dwell in ticks (legal range 1..15).
REQ-003 SHALL have parameter WALK_TICKS, default 6, red+walk dwell in ticks (legal range 1..15).
REQ-004 SHALL have parameter CLEAR_TICKS, default 2, all-red clearance dwell in ticks (legal range 1..15).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port tick, input, 1 bit: one-cycle time-base enable produced by the upstream clock divider.
REQ-008 SHALL have port ped_req, input, 1 bit: pedestrian request, sampled every clk (not gated by tick).
REQ-009 SHALL have port ped_ack, output, 1 bit: one-cycle pulse acknowledging that a latched request is being served.
REQ-010 SHALL have port car_light, output, 3 bits: one-hot {red, yellow, green}.
REQ-011 SHALL have port walk, output, 1 bit: pedestrian walk lamp.
REQ-012 SHALL have port dwell, output, 4 bits: current dwell-counter value, for observation.

Function
REQ-013 SHALL implement four states: GREEN, YELLOW, WALK, CLEAR.
REQ-014 SHALL keep a 4-bit dwell counter that increments only on clk edges where tick=1, and clears to 0 on every state change.
REQ-015 SHALL in GREEN saturate the dwell counter at GREEN_TICKS-1 (no wrap-around).
REQ-016 SHALL leave GREEN for YELLOW on the first tick edge where the counter equals GREEN_TICKS-1 and the request latch is set; otherwise remain in GREEN indefinitely.
REQ-017 SHALL go YELLOW->WALK, WALK->CLEAR and CLEAR->GREEN on the tick edge where the counter equals the respective DUR-1, without condition.
REQ-018 SHALL hold a request latch, set on any clk edge where ped_req=1, and cleared on the YELLOW->WALK edge.
REQ-019 SHALL give set priority over clear: if ped_req=1 on the YELLOW->WALK edge, the latch stays set, and that request is served in the next cycle.
REQ-020 SHALL assert ped_ack for exactly the one cycle following the YELLOW->WALK edge.
REQ-021 SHALL decode the outputs from the state register as follows, changing on the same edge as the state (zero added latency):
- GREEN = car_light 001, walk 0
- YELLOW = car_light 010, walk 0
- WALK = car_light 100, walk 1
- CLEAR = car_light 100, walk 0
REQ-022 SHALL ignore tick while rst_n=0; a tick coincident with the release of rst_n is not counted.
REQ-023 SHALL never drive walk=1 while car_light[0] or car_light[1] is 1 (safety invariant).

Reset
REQ-024 SHALL on rst_n=0, asynchronously and regardless of clk, force:
- state to GREEN
- dwell counter to 0
- request latch to 0
- ped_ack to 0
- car_light to 001, walk to 0
REQ-025 SHALL, when reset is applied mid-phase (e.g. during WALK), drop walk on the reset assertion itself, not on a later clk edge.

Structure
REQ-026 SHALL place the state enumeration type, the car_light encodings, and the dwell-counter width constant (4) in the shared package traffic_pkg.
REQ-027 SHALL implement the dwell counter as sub-module dwell_counter (ports: clk, rst_n, en, clr, sat, count).
REQ-028 SHALL reject out-of-range parameter values (0 or greater than 15) at elaboration.

Verification
REQ-029 SHALL verify idle: defaults, tick every 2 clk, ped_req=0 for 100 clk -> car_light stays 001, dwell saturates at 7, ped_ack never 1.
REQ-030 SHALL verify a normal cycle: ped_req pulsed 1 clk at cycle 3 -> YELLOW entered on the 8th tick, WALK on the 11th tick with a single ped_ack pulse, CLEAR on the 17th tick, GREEN on the 19th tick.
REQ-031 SHALL verify set priority: ped_req held high across the YELLOW->WALK edge -> latch still 1 in WALK, and the next GREEN lasts exactly 8 ticks before YELLOW.
REQ-032 SHALL verify reset mid-operation: rst_n asserted low between clk edges while in WALK -> walk=0 and car_light=001 immediately; after release, 8 further ticks are needed before YELLOW.
REQ-033 SHALL verify the tick gate: tick held 0 for 50 clk in YELLOW -> state and dwell unchanged.
REQ-034 SHALL check the REQ-023 invariant, and car_light one-hot, on every clk in all scenarios.
